// File: rtl/hazard_pkg.sv
// Shared types for the execute-stage hazard controller: forward-select codes,
// pipeline slot control bits and the controller FSM states.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Register addresses live beside this struct so their width can follow REG_ADDR_W.
    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic use_rs1;
        logic use_rs2;
    } slot_ctrl_t;

    localparam int CTRL_W = $bits(slot_ctrl_t);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } hz_state_t;

endpackage

// File: rtl/hazard_slot_reg.sv
// One pipeline slot (EX, MEM or WB) of hazard bookkeeping; synchronous clear on
// rst, and bubble zeroes the control bits so the slot reads as empty.
module hazard_slot_reg
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bubble,
    input  logic [CTRL_W-1:0]     nxt_ctrl,
    input  logic [REG_ADDR_W-1:0] nxt_rd,
    input  logic [REG_ADDR_W-1:0] nxt_rs1,
    input  logic [REG_ADDR_W-1:0] nxt_rs2,
    output logic [CTRL_W-1:0]     ctrl,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [REG_ADDR_W-1:0] rs1,
    output logic [REG_ADDR_W-1:0] rs2
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl <= '0;
            rd   <= '0;
            rs1  <= '0;
            rs2  <= '0;
        end else begin
            ctrl <= bubble ? '0 : nxt_ctrl;
            rd   <= nxt_rd;
            rs1  <= nxt_rs1;
            rs2  <= nxt_rs2;
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Execute-stage forwarding, load-use stall and branch flush control.
// Define HAZARD_FWD_EN for operand forwarding; otherwise every RAW hazard stalls.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic                  stall,
    output logic                  flush_id,
    output logic                  flush_ex,
    output logic [CNT_W-1:0]      stall_count
);

    slot_ctrl_t            id_ctrl, ex_ctrl, mem_ctrl, wb_ctrl;
    logic [REG_ADDR_W-1:0] ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
    logic                  hazard;
    logic                  unused_bits;
    hz_state_t             state;

    function automatic logic writes(slot_ctrl_t c, logic [REG_ADDR_W-1:0] rd,
                                    logic [REG_ADDR_W-1:0] r);
        return c.valid && c.reg_write && (rd == r) && (r != '0);
    endfunction

    always_comb begin
        id_ctrl = '0;
        if (id_valid) begin
            id_ctrl.valid     = 1'b1;
            id_ctrl.reg_write = id_reg_write;
            id_ctrl.mem_read  = id_mem_read;
            id_ctrl.use_rs1   = id_use_rs1;
            id_ctrl.use_rs2   = id_use_rs2;
        end
    end

    hazard_slot_reg #(.REG_ADDR_W(REG_ADDR_W)) u_ex (
        .clk(clk), .rst(rst), .bubble(stall | flush_ex),
        .nxt_ctrl(id_ctrl), .nxt_rd(id_rd), .nxt_rs1(id_rs1), .nxt_rs2(id_rs2),
        .ctrl(ex_ctrl), .rd(ex_rd), .rs1(ex_rs1), .rs2(ex_rs2)
    );

    hazard_slot_reg #(.REG_ADDR_W(REG_ADDR_W)) u_mem (
        .clk(clk), .rst(rst), .bubble(1'b0),
        .nxt_ctrl(ex_ctrl), .nxt_rd(ex_rd), .nxt_rs1('0), .nxt_rs2('0),
        .ctrl(mem_ctrl), .rd(mem_rd), .rs1(), .rs2()
    );

    hazard_slot_reg #(.REG_ADDR_W(REG_ADDR_W)) u_wb (
        .clk(clk), .rst(rst), .bubble(1'b0),
        .nxt_ctrl(mem_ctrl), .nxt_rd(mem_rd), .nxt_rs1('0), .nxt_rs2('0),
        .ctrl(wb_ctrl), .rd(wb_rd), .rs1(), .rs2()
    );

`ifdef HAZARD_FWD_EN
    function automatic logic [1:0] fwd_src(logic use_src, logic [REG_ADDR_W-1:0] src);
        if (!use_src)                     return FWD_RF;
        if (writes(mem_ctrl, mem_rd, src)) return FWD_MEM;
        if (writes(wb_ctrl, wb_rd, src))   return FWD_WB;
        return FWD_RF;
    endfunction

    assign fwd_sel_a = rst ? FWD_RF : fwd_src(ex_ctrl.use_rs1, ex_rs1);
    assign fwd_sel_b = rst ? FWD_RF : fwd_src(ex_ctrl.use_rs2, ex_rs2);

    // Only a load in EX is too late to forward; everything else is bypassed.
    assign hazard = id_valid && ex_ctrl.mem_read &&
                    ((id_use_rs1 && writes(ex_ctrl, ex_rd, id_rs1)) ||
                     (id_use_rs2 && writes(ex_ctrl, ex_rd, id_rs2)));

    assign unused_bits = ^{mem_ctrl.mem_read, mem_ctrl.use_rs1, mem_ctrl.use_rs2,
                           wb_ctrl.mem_read, wb_ctrl.use_rs1, wb_ctrl.use_rs2};
`else
    function automatic logic src_busy(logic use_src, logic [REG_ADDR_W-1:0] src);
        return use_src && (writes(ex_ctrl, ex_rd, src) ||
                           writes(mem_ctrl, mem_rd, src) ||
                           writes(wb_ctrl, wb_rd, src));
    endfunction

    assign fwd_sel_a = FWD_RF;
    assign fwd_sel_b = FWD_RF;

    // No bypass anywhere: hold the consumer until its producer has left WB.
    assign hazard = id_valid && (src_busy(id_use_rs1, id_rs1) || src_busy(id_use_rs2, id_rs2));

    assign unused_bits = ^{ex_rs1, ex_rs2, ex_ctrl.mem_read, ex_ctrl.use_rs1, ex_ctrl.use_rs2,
                           mem_ctrl.mem_read, mem_ctrl.use_rs1, mem_ctrl.use_rs2,
                           wb_ctrl.mem_read, wb_ctrl.use_rs1, wb_ctrl.use_rs2};
`endif

    assign flush_id = ex_branch_taken && !rst;
    assign flush_ex = ex_branch_taken && !rst;
    assign stall    = hazard && !ex_branch_taken && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            stall_count <= '0;
        end else begin
            if (flush_ex)   state <= ST_FLUSH;
            else if (stall) state <= ST_STALL;
            else            state <= ST_RUN;
            if (stall && stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
        end
    end

    // A flush or stall always leaves a bubble in EX behind it.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_FLUSH)
            assert (!ex_ctrl.valid);
`ifdef HAZARD_FWD_EN
        if (!rst && state == ST_STALL)
            assert (!stall);
`endif
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed-vector bench for hazard_forward_ctrl; expectations follow the
// HAZARD_FWD_EN setting of the build.
module tb_hazard_forward_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
    logic        ex_branch_taken;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic        stall, flush_id, flush_ex;
    logic [15:0] stall_count;

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;

    hazard_forward_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .stall(stall), .flush_id(flush_id), .flush_ex(flush_ex),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One pipeline cycle: drive ID, check outputs mid-cycle, then take the edge.
    task automatic cyc(input logic r, v, input logic [4:0] rd, rs1, rs2,
                       input logic u1, u2, rw, mr, br,
                       input logic [1:0] ea, eb, input logic es, ef,
                       input logic [15:0] ecnt);
        rst = r; id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_use_rs1 = u1; id_use_rs2 = u2; id_reg_write = rw; id_mem_read = mr;
        ex_branch_taken = br;
        @(negedge clk);
        cyc_n++;
        check($sformatf("c%0d_fwd_a", cyc_n), 32'(fwd_sel_a), 32'(ea));
        check($sformatf("c%0d_fwd_b", cyc_n), 32'(fwd_sel_b), 32'(eb));
        check($sformatf("c%0d_stall", cyc_n), 32'(stall), 32'(es));
        check($sformatf("c%0d_flush_id", cyc_n), 32'(flush_id), 32'(ef));
        check($sformatf("c%0d_flush_ex", cyc_n), 32'(flush_ex), 32'(ef));
        check($sformatf("c%0d_stall_cnt", cyc_n), 32'(stall_count), 32'(ecnt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_reg_write = 1'b0;
        id_mem_read = 1'b0; ex_branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // reset held with a live instruction and a taken branch: everything quiet
        cyc(1, 1, 6, 5, 1, 1, 1, 1, 0, 1,  2'd0, 2'd0, 0, 0, 16'd0);
`ifdef HAZARD_FWD_EN
        cyc(0, 1, 5, 1, 2, 1, 1, 1, 0, 0,  2'd0, 2'd0, 0, 0, 16'd0); // add x5,x1,x2
        cyc(0, 1, 6, 5, 3, 1, 1, 1, 0, 0,  2'd0, 2'd0, 0, 0, 16'd0); // sub x6,x5,x3
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  2'd2, 2'd0, 0, 0, 16'd0); // sub in EX: MEM fwd
        cyc(0, 1, 5, 1, 2, 1, 1, 1, 0, 0,  2'd0, 2'd0, 0, 0, 16'd0); // add x5
        cyc(0, 1, 8, 1, 2, 1, 1, 1, 0, 0,  2'd0, 2'd0, 0, 0, 16'd0); // and x8 (unrelated)
        cyc(0, 1, 7, 4, 5, 1, 1, 1, 0, 0,  2'd0, 2'd0, 0, 0, 16'd0); // or x7,x4,x5
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  2'd0, 2'd1, 0, 0, 16'd0); // or in EX: WB fwd on b
        cyc(0, 1, 5, 1, 0, 1, 0, 1, 1, 0,  2'd0, 2'd0, 0, 0, 16'd0); // lw x5,0(x1)
        cyc(0, 1, 6, 5, 1, 1, 1, 1, 0, 0,  2'd0, 2'd0, 1, 0, 16'd0); // add x6,x5,x1: load-use
        cyc(0, 1, 6, 5, 1, 1, 1, 1, 0, 0,  2'd0, 2'd0, 0, 0, 16'd1); // held, single stall
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  2'd1, 2'd0, 0, 0, 16'd1); // add in EX: WB fwd
        cyc(0, 1, 0, 1, 2, 1, 1, 1, 0, 0,  2'd0, 2'd0, 0, 0, 16'd1); // add x0,x1,x2
        cyc(0, 1, 9, 0, 0, 1, 1, 1, 0, 0,  2'd0, 2'd0, 0, 0, 16'd1); // sub x9,x0,x0
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  2'd0, 2'd0, 0, 0, 16'd1); // x0 never forwarded
        cyc(0, 1, 5, 1, 0, 1, 0, 1, 1, 0,  2'd0, 2'd0, 0, 0, 16'd1); // lw x5
        cyc(0, 1, 6, 5, 1, 1, 1, 1, 0, 1,  2'd0, 2'd0, 0, 1, 16'd1); // load-use + branch
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  2'd0, 2'd0, 0, 0, 16'd1); // count unchanged
        cyc(0, 1, 5, 1, 0, 1, 0, 1, 1, 0,  2'd0, 2'd0, 0, 0, 16'd1); // lw x5,0(x1)
        cyc(0, 1, 6, 1, 0, 1, 0, 1, 1, 0,  2'd0, 2'd0, 0, 0, 16'd1); // lw x6,0(x1)
        cyc(0, 1, 7, 5, 6, 1, 1, 1, 0, 0,  2'd0, 2'd0, 1, 0, 16'd1); // add x7,x5,x6
        cyc(0, 1, 7, 5, 6, 1, 1, 1, 0, 0,  2'd0, 2'd0, 0, 0, 16'd2); // only one stall
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  2'd0, 2'd1, 0, 0, 16'd2); // x6 from WB
        cyc(0, 1, 5, 1, 0, 1, 0, 1, 1, 0,  2'd0, 2'd0, 0, 0, 16'd2); // lw x5
        cyc(1, 1, 6, 5, 1, 1, 1, 1, 0, 0,  2'd0, 2'd0, 0, 0, 16'd2); // rst over load-use
        cyc(0, 1, 6, 5, 1, 1, 1, 1, 0, 0,  2'd0, 2'd0, 0, 0, 16'd0); // clean pipeline
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  2'd0, 2'd0, 0, 0, 16'd0);
`else
        cyc(0, 1, 5, 1, 2, 1, 1, 1, 0, 0,  2'd0, 2'd0, 0, 0, 16'd0); // add x5,x1,x2
        cyc(0, 1, 6, 5, 3, 1, 1, 1, 0, 0,  2'd0, 2'd0, 1, 0, 16'd0); // sub: producer in EX
        cyc(0, 1, 6, 5, 3, 1, 1, 1, 0, 0,  2'd0, 2'd0, 1, 0, 16'd1); // producer in MEM
        cyc(0, 1, 6, 5, 3, 1, 1, 1, 0, 0,  2'd0, 2'd0, 1, 0, 16'd2); // producer in WB
        cyc(0, 1, 6, 5, 3, 1, 1, 1, 0, 0,  2'd0, 2'd0, 0, 0, 16'd3); // released
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  2'd0, 2'd0, 0, 0, 16'd3);
        cyc(0, 1, 0, 1, 2, 1, 1, 1, 0, 0,  2'd0, 2'd0, 0, 0, 16'd3); // add x0,x1,x2
        cyc(0, 1, 9, 0, 0, 1, 1, 1, 0, 0,  2'd0, 2'd0, 0, 0, 16'd3); // sub x9,x0,x0: no stall
        cyc(0, 1, 5, 1, 0, 1, 0, 1, 1, 0,  2'd0, 2'd0, 0, 0, 16'd3); // lw x5
        cyc(0, 1, 6, 5, 1, 1, 1, 1, 0, 1,  2'd0, 2'd0, 0, 1, 16'd3); // hazard + branch
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  2'd0, 2'd0, 0, 0, 16'd3); // count unchanged
        cyc(0, 1, 5, 1, 2, 1, 1, 1, 0, 0,  2'd0, 2'd0, 0, 0, 16'd3); // add x5
        cyc(0, 1, 6, 5, 3, 1, 1, 1, 0, 0,  2'd0, 2'd0, 1, 0, 16'd3); // sub stalls
        cyc(0, 1, 6, 5, 3, 1, 1, 1, 0, 0,  2'd0, 2'd0, 1, 0, 16'd4);
        cyc(1, 1, 6, 5, 3, 1, 1, 1, 0, 0,  2'd0, 2'd0, 0, 0, 16'd5); // rst mid-stall
        cyc(0, 1, 6, 5, 3, 1, 1, 1, 0, 0,  2'd0, 2'd0, 0, 0, 16'd0); // clean pipeline
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  2'd0, 2'd0, 0, 0, 16'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
